// File: rtl/alu_chain_seq_if.sv
// Bus between the multi-word sequencer (initiator) and one combinational N-bit ALU.
interface alu_chain_seq_if #(
  parameter int N    = 8,
  parameter int AC_N = 3
);
  logic [AC_N-1:0] alu_cs;
  logic [N-1:0]    alu_a;
  logic [N-1:0]    alu_b;
  logic            alu_cin;
  logic [N-1:0]    alu_s;
  logic            alu_zero;
  logic            alu_cout;

  modport master (output alu_cs, alu_a, alu_b, alu_cin,
                  input  alu_s, alu_zero, alu_cout);
  modport slave  (input  alu_cs, alu_a, alu_b, alu_cin,
                  output alu_s, alu_zero, alu_cout);
endinterface

// File: rtl/alu_chain_seq.sv
// Arbitrary-precision ADD/SUB/AND/OR built by chaining word operations through an
// external N-bit ALU, with a one-deep registered result stage and whole-value flags.
module alu_chain_seq #(
  parameter int              N      = 8,
  parameter int              LW     = 4,
  parameter int              AC_N   = 3,
  parameter logic [AC_N-1:0] AC_AD  = AC_N'(0),
  parameter logic [AC_N-1:0] AC_SB  = AC_N'(1),
  parameter logic [AC_N-1:0] AC_ADX = AC_N'(2),
  parameter logic [AC_N-1:0] AC_SBX = AC_N'(3),
  parameter logic [AC_N-1:0] AC_AN  = AC_N'(4),
  parameter logic [AC_N-1:0] AC_OR  = AC_N'(5)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [LW-1:0] len,
  output logic          busy,
  output logic          done,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_a,
  input  logic [N-1:0]  in_b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_s,
  output logic          out_last,
  output logic          flag_c,
  output logic          flag_z,
  alu_chain_seq_if.master alu
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t        state_q, state_d;
  logic [1:0]    op_q;
  logic [LW-1:0] cnt_q;
  logic          first_q;
  logic          zacc_q;
  logic          creg_q;
  logic          last_acc_q;
  logic          start_acc;
  logic          in_acc;
  logic          out_hs;
  logic          last_word;

  assign out_hs    = out_valid && out_ready;
  assign in_acc    = in_valid && in_ready;
  assign last_word = (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    busy          = 1'b0;
    done          = 1'b0;
    in_ready      = 1'b0;
    start_acc     = 1'b0;
    alu.alu_a     = in_a;
    alu.alu_b     = in_b;
    alu.alu_cs    = AC_ADX;
    alu.alu_cin   = 1'b0;
    case (state_q)
      S_IDLE: begin
        start_acc = start;
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        busy     = 1'b1;
        in_ready = !last_acc_q && (!out_valid || out_ready);
        if (out_hs && out_last) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
        // The ALU carry-in for subtraction means "no borrow", hence the inversion.
        case (op_q)
          2'b00: begin
            alu.alu_cs  = first_q ? AC_ADX : AC_AD;
            alu.alu_cin = !first_q && creg_q;
          end
          2'b01: begin
            alu.alu_cs  = first_q ? AC_SBX : AC_SB;
            alu.alu_cin = !first_q && !creg_q;
          end
          2'b10:   alu.alu_cs = AC_AN;
          default: alu.alu_cs = AC_OR;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= 2'b00;
      cnt_q      <= '0;
      first_q    <= 1'b1;
      zacc_q     <= 1'b1;
      creg_q     <= 1'b0;
      last_acc_q <= 1'b0;
      out_valid  <= 1'b0;
      out_s      <= '0;
      out_last   <= 1'b0;
      flag_c     <= 1'b0;
      flag_z     <= 1'b0;
    end else begin
      if (start_acc) begin
        op_q       <= op;
        cnt_q      <= len;
        first_q    <= 1'b1;
        zacc_q     <= 1'b1;
        creg_q     <= 1'b0;
        last_acc_q <= 1'b0;
        flag_c     <= 1'b0;
        flag_z     <= 1'b0;
      end
      // An accept refills the output stage even when it drains in the same cycle.
      if (in_acc) begin
        out_s     <= alu.alu_s;
        out_valid <= 1'b1;
        out_last  <= last_word;
        creg_q    <= alu.alu_cout;
        zacc_q    <= zacc_q & alu.alu_zero;
        first_q   <= 1'b0;
        cnt_q     <= cnt_q - 1'b1;
        if (last_word) begin
          last_acc_q <= 1'b1;
          flag_c     <= !op_q[1] && alu.alu_cout;
          flag_z     <= zacc_q & alu.alu_zero;
        end
      end else if (out_hs) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule
